// File: rtl/ysyx_23060025_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060025_lsu_pkg
//  Description : Shared definitions for the AXI load/store unit. Holds the
//                FSM state encodings, access size codes, AXI response codes
//                and the alignment test helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060025_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RESP    = 3'd5
  } lsu_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // A half must sit on an even address, a word on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060025_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060025_lsu_align
//  Description : Purely combinational lane steering. Places store data and
//                byte strobes on the lanes selected by the low address bits,
//                and brings load data back down to bit 0 with sign or zero
//                extension to the full data width.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060025_lsu_align
  import ysyx_23060025_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [1:0]          addr_lo,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  input  logic [DATA_LEN-1:0] wdata_in,
  input  logic [DATA_LEN-1:0] rdata_in,
  output logic [DATA_LEN-1:0] wdata_out,
  output logic [3:0]          wstrb_out,
  output logic [DATA_LEN-1:0] rdata_out
);

  logic [DATA_LEN-1:0] w_rshift;
  logic [3:0]          w_strb_base;

  // Store side: shift data and strobes up to the addressed byte lane; strobes
  // that run past lane 3 are simply dropped by the 4-bit result.
  always_comb begin
    w_strb_base = 4'hF;
    case (size)
      SIZE_BYTE: w_strb_base = 4'h1;
      SIZE_HALF: w_strb_base = 4'h3;
      default:   w_strb_base = 4'hF;
    endcase
    wstrb_out = w_strb_base << addr_lo;
    wdata_out = wdata_in << {addr_lo, 3'b000};
  end

  // Load side: shift the addressed lane down, then extend to full width.
  always_comb begin
    w_rshift = rdata_in >> {addr_lo, 3'b000};
    case (size)
      SIZE_BYTE: rdata_out = {{(DATA_LEN-8){~is_unsigned & w_rshift[7]}}, w_rshift[7:0]};
      SIZE_HALF: rdata_out = {{(DATA_LEN-16){~is_unsigned & w_rshift[15]}}, w_rshift[15:0]};
      default:   rdata_out = w_rshift;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060025_lsu_axi.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060025_lsu_axi
//  Description : Single-outstanding load/store unit with an AXI master port.
//                A request is latched in IDLE, issued as AR/R or AW+W/B, and
//                the extended result is held on the response port until it is
//                taken. Define YSYX_23060025_LSU_MISALIGN_CHK_EN to reject
//                misaligned half/word accesses with an error instead of
//                issuing them on the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060025_lsu_axi
  import ysyx_23060025_lsu_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  // request / response
  input  logic                req_valid,
  input  logic                req_wen,
  input  logic                req_unsigned,
  input  logic [1:0]          req_size,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                req_ready,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic                resp_err,
  // AXI read
  output logic [ADDR_LEN-1:0] ar_addr,
  output logic [2:0]          ar_size,
  output logic                ar_valid,
  input  logic                ar_ready,
  input  logic [DATA_LEN-1:0] r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_valid,
  input  logic                r_last,
  output logic                r_ready,
  // AXI write
  output logic [ADDR_LEN-1:0] aw_addr,
  output logic [2:0]          aw_size,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [DATA_LEN-1:0] w_data,
  output logic [3:0]          w_strb,
  output logic                w_valid,
  input  logic                w_ready,
  input  logic [1:0]          b_resp,
  input  logic                b_valid,
  output logic                b_ready
);

  lsu_state_t          r_state, w_next;
  logic [ADDR_LEN-1:0] r_addr;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [DATA_LEN-1:0] r_wdata;
  logic [DATA_LEN-1:0] r_rdata;
  logic                r_err;
  logic                r_aw_done;
  logic                r_w_done;
  logic                w_accept;
  logic                w_misalign;
  logic                w_r_last_hs;
  logic [DATA_LEN-1:0] w_wdata_al;
  logic [3:0]          w_strb_al;
  logic [DATA_LEN-1:0] w_load_data;

`ifdef YSYX_23060025_LSU_MISALIGN_CHK_EN
  assign w_misalign = is_misaligned(req_size, req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept    = req_valid & req_ready;
  assign w_r_last_hs = r_valid & r_ready & r_last;

  ysyx_23060025_lsu_align #(
    .DATA_LEN (DATA_LEN)
  ) u_align (
    .addr_lo     (r_addr[1:0]),
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .wdata_in    (r_wdata),
    .rdata_in    (r_data),
    .wdata_out   (w_wdata_al),
    .wstrb_out   (w_strb_al),
    .rdata_out   (w_load_data)
  );

  // Request fields come straight from the latched copy so the bus stays stable.
  assign ar_addr    = r_addr;
  assign ar_size    = {1'b0, r_size};
  assign aw_addr    = r_addr;
  assign aw_size    = {1'b0, r_size};
  assign w_data     = w_wdata_al;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // State register plus latched request, handshake progress and result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_size     <= SIZE_BYTE;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr     <= req_addr;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata;
        r_rdata    <= '0;
        r_err      <= w_misalign;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
      end
      if (aw_valid && aw_ready) r_aw_done <= 1'b1;
      if (w_valid && w_ready)   r_w_done  <= 1'b1;
      if (w_r_last_hs) begin
        r_rdata <= w_load_data;
        r_err   <= (r_resp != AXI_RESP_OKAY);
      end
      if (b_valid && b_ready) begin
        r_err <= (b_resp != AXI_RESP_OKAY);
      end
    end
  end

  // Next-state and handshake outputs, decoded from the current state only.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    w_strb     = 4'h0;
    b_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_misalign)   w_next = ST_RESP;
          else if (req_wen) w_next = ST_WR;
          else              w_next = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) w_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        r_ready = 1'b1;
        if (r_valid && r_last) w_next = ST_RESP;
      end
      ST_WR: begin
        aw_valid = ~r_aw_done;
        w_valid  = ~r_w_done;
        w_strb   = w_strb_al;
        if ((r_aw_done || aw_ready) && (r_w_done || w_ready)) w_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        b_ready = 1'b1;
        if (b_valid) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060025_lsu_axi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_23060025_lsu_axi
//  Description : Directed self-checking bench for the AXI load/store unit.
//                Expected responses are queued when a request is issued and
//                compared when the unit presents its response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060025_lsu_axi;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ar_addr, aw_addr, r_data, w_data;
  logic [2:0]  ar_size, aw_size;
  logic        ar_valid, ar_ready, r_valid, r_last, r_ready;
  logic [1:0]  r_resp, b_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [3:0]  w_strb;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   t0     = 0;

  ysyx_23060025_lsu_axi #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_wen(req_wen), .req_unsigned(req_unsigned),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ar_addr(ar_addr), .ar_size(ar_size), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready),
    .aw_addr(aw_addr), .aw_size(aw_size), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Present one request for a single cycle, then scramble the request inputs.
  task automatic issue(input logic wen, input logic uns, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_wen = wen; req_unsigned = uns;
    req_size = size; req_addr = addr; req_wdata = wdata;
    check("req_ready_idle", req_ready, 1);
    check("no_valid_idle", {ar_valid, aw_valid, w_valid}, 0);
    t0 = cyc;
    step();
    req_valid = 1'b0; req_wen = ~wen; req_unsigned = ~uns;
    req_size = 2'b11; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
  endtask

  // Wait (bounded) for the response, hold it off for 'hold' cycles, then take it.
  task automatic wait_resp(input int exp_lat, input int hold, input logic hold_err);
    exp_t e;
    int n = 0;
    while (!resp_valid && n < 20) begin
      step();
      n++;
    end
    check("resp_arrived", resp_valid, 1);
    check("resp_latency", cyc - t0, exp_lat);
    for (int i = 0; i < hold; i++) begin
      check("resp_hold_valid", resp_valid, 1);
      check("resp_hold_err", resp_err, hold_err);
      step();
    end
    check("resp_still_valid", resp_valid, 1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_err", resp_err, e.err);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_dropped", resp_valid, 0);
    check("back_to_idle", req_ready, 1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] data, input logic [1:0] resp,
                         input logic [31:0] exp_rdata, input logic exp_err);
    push_exp(exp_rdata, exp_err);
    issue(1'b0, uns, size, addr, 32'h0);
    check("ar_valid", ar_valid, 1);
    check("ar_addr", ar_addr, addr);
    check("ar_size", ar_size, {1'b0, size});
    check("r_ready_early", r_ready, 0);
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    check("ar_valid_drop", ar_valid, 0);
    check("r_ready", r_ready, 1);
    r_valid = 1'b1; r_last = 1'b1; r_data = data; r_resp = resp;
    step();
    r_valid = 1'b0; r_last = 1'b0; r_data = 32'h0; r_resp = 2'b00;
    wait_resp(3, 0, exp_err);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                          input int aw_dly, input int w_dly, input logic [1:0] bresp,
                          input int hold, input logic exp_err);
    int last = (aw_dly > w_dly) ? aw_dly : w_dly;
    push_exp(32'h0, exp_err);
    issue(1'b1, 1'b0, size, addr, wdata);
    check("aw_addr", aw_addr, addr);
    check("aw_size", aw_size, {1'b0, size});
    check("w_data", w_data, exp_wdata);
    check("w_strb", w_strb, exp_strb);
    for (int k = 0; k <= last; k++) begin
      aw_ready = (k == aw_dly);
      w_ready  = (k == w_dly);
      check("aw_valid_phase", aw_valid, (k <= aw_dly));
      check("w_valid_phase", w_valid, (k <= w_dly));
      step();
    end
    aw_ready = 1'b0; w_ready = 1'b0;
    check("wr_valids_done", {aw_valid, w_valid}, 0);
    check("b_ready", b_ready, 1);
    b_valid = 1'b1; b_resp = bresp;
    step();
    b_valid = 1'b0; b_resp = 2'b00;
    check("b_ready_drop", b_ready, 0);
    wait_resp(last + 3, hold, exp_err);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_unsigned = 1'b0;
    req_size = 2'd0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    ar_ready = 1'b0; r_data = 32'h0; r_resp = 2'b00; r_valid = 1'b0; r_last = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; b_resp = 2'b00; b_valid = 1'b0;
    step();
    step();
    check("rst_req_ready", req_ready, 1);
    check("rst_valids", {ar_valid, aw_valid, w_valid, resp_valid}, 0);
    check("rst_readies", {r_ready, b_ready}, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_w_strb", w_strb, 0);
    reset = 1'b0;
    step();

    // word load, zero-wait slave
    do_load(32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0);
    // byte loads from the top lane, signed and unsigned
    do_load(32'h8000_0003, 2'd0, 1'b0, 32'h8011_2233, 2'b00, 32'hFFFF_FF80, 1'b0);
    do_load(32'h8000_0003, 2'd0, 1'b1, 32'h8011_2233, 2'b00, 32'h0000_0080, 1'b0);
    // signed half from the upper lanes
    do_load(32'h8000_0002, 2'd1, 1'b0, 32'h8001_1234, 2'b00, 32'hFFFF_8001, 1'b0);
    // slave error on a read keeps the data and flags the error
    do_load(32'h8000_0008, 2'd2, 1'b0, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D, 1'b1);

    // word store, zero-wait
    do_store(32'h8000_0000, 2'd2, 32'h1234_5678, 32'h1234_5678, 4'hF, 0, 0, 2'b00, 0, 1'b0);
    // byte store into lane 1
    do_store(32'h8000_0001, 2'd0, 32'h0000_00AB, 32'h0000_AB00, 4'b0010, 0, 0, 2'b00, 0, 1'b0);
    // half store, AW accepted two cycles ahead of W
    do_store(32'h8000_0002, 2'd1, 32'h0000_ABCD, 32'hABCD_0000, 4'b1100, 0, 2, 2'b00, 0, 1'b0);
    // error write response, response held off for three cycles
    do_store(32'h8000_0010, 2'd2, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 4'hF, 1, 0, 2'b10, 3, 1'b1);

    // reset in the middle of a read data phase
    issue(1'b0, 1'b0, 2'd2, 32'h8000_0020, 32'h0);
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    check("pre_rst_r_ready", r_ready, 1);
    reset = 1'b1;
    step();
    check("mid_rst_r_ready", r_ready, 0);
    check("mid_rst_ar_valid", ar_valid, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_resp_valid", resp_valid, 0);
    reset = 1'b0;
    step();

    // misaligned word load
`ifdef YSYX_23060025_LSU_MISALIGN_CHK_EN
    push_exp(32'h0, 1'b1);
    issue(1'b0, 1'b0, 2'd2, 32'h8000_0001, 32'h0);
    check("misalign_no_ar", ar_valid, 0);
    check("misalign_resp_now", resp_valid, 1);
    check("misalign_err_now", resp_err, 1);
    wait_resp(1, 0, 1'b1);
    check("misalign_no_ar_after", ar_valid, 0);
`else
    do_load(32'h8000_0001, 2'd2, 1'b0, 32'h1122_3344, 2'b00, 32'h0011_2233, 1'b0);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060025_lsu_axi.md
YSYX_23060025_LSU_AXI -- requirements
Module: ysyx_23060025_lsu_axi

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 32, address width.
REQ-002 SHALL have parameter DATA_LEN, default 32, data width.
REQ-003 clock  in  1  clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 req_valid/req_wen/req_unsigned  in  1 each  request valid, store(1)/load(0), zero-extend load.
REQ-006 req_size in 2 (0 byte, 1 half, 2 word); req_addr in ADDR_LEN; req_wdata in DATA_LEN (value right-aligned).
REQ-007 req_ready  out  1  request accepted when req_valid&req_ready.
REQ-008 resp_valid out 1; resp_ready in 1; resp_rdata out DATA_LEN (extended load data, 0 for stores); resp_err out 1.
REQ-009 ar_addr out ADDR_LEN; ar_size out 3; ar_valid out 1; ar_ready in 1.
REQ-010 r_data in DATA_LEN; r_resp in 2; r_valid in 1; r_last in 1; r_ready out 1.
REQ-011 aw_addr out ADDR_LEN; aw_size out 3; aw_valid out 1; aw_ready in 1.
REQ-012 w_data out DATA_LEN; w_strb out 4; w_valid out 1; w_ready in 1.
REQ-013 b_resp in 2; b_valid in 1; b_ready out 1.

Function
REQ-014 States IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 Accepted load: IDLE->RD_ADDR; ar_valid=1 from next cycle, held with stable ar_addr/ar_size until ar_ready.
REQ-016 RD_ADDR->RD_DATA on ar_valid&ar_ready; r_ready=1 only in RD_DATA; r_valid&r_last -> capture data/resp, go RESP.
REQ-017 Accepted store: IDLE->WR; aw_valid and w_valid SHALL both rise in the same cycle; each drops individually after its own handshake; both done -> WR_RESP.
REQ-018 WR_RESP: b_ready=1; b_valid -> capture b_resp, go RESP.
REQ-019 RESP: resp_valid=1, outputs stable until resp_ready; resp_valid&resp_ready -> IDLE.
REQ-020 ar_size/aw_size = {1'b0, req_size}; ar_addr/aw_addr = req_addr unmodified.
REQ-021 w_data = req_wdata << (8*addr[1:0]); w_strb = (1/3/F by size) << addr[1:0], truncated to 4 bits.
REQ-022 Load data = r_data >> (8*addr[1:0]), truncated to size, sign-extended unless req_unsigned.
REQ-023 resp_err = 1 when captured r_resp or b_resp != 2'b00.
REQ-024 Minimum latency: load/store accepted cycle 0 with zero-wait slave -> resp_valid in cycle 3.
REQ-025 Request fields SHALL be registered on acceptance; later input changes ignored until IDLE.

Reset
REQ-026 On reset: state IDLE; req_ready=1; all valid/ready outputs, resp_err, resp_rdata, w_strb = 0 next cycle, including mid-transaction.

Configuration
REQ-027 With YSYX_23060025_LSU_MISALIGN_CHK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE->RESP directly, resp_err=1, resp_rdata=0, no AXI valid asserted.
REQ-028 Without the macro: misaligned requests SHALL be issued per REQ-015..022 unchanged.

Structure
REQ-029 Shared package/define file SHALL hold state encodings, size codes, AXI resp codes (OKAY=2'b00).
REQ-030 Alignment/extension logic (REQ-021, REQ-022) SHALL be sub-module ysyx_23060025_lsu_align, purely combinational.

Verification
REQ-031 Load word 0x8000_0004, r_data=0xDEADBEEF, r_resp=0 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid cycle 3.
REQ-032 Signed byte load 0x8000_0003, r_data=0x80112233 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-033 Half store 0xABCD to 0x8000_0002 -> w_data=0xABCD0000, w_strb=4'b1100, aw_valid/w_valid rise together; aw_ready 2 cycles before w_ready -> one B then resp.
REQ-034 b_resp=2'b10, resp_ready low 3 cycles -> resp_valid/resp_err=1 held 4 cycles, then IDLE.
REQ-035 Reset asserted in RD_DATA -> next cycle r_ready=0, ar_valid=0, req_ready=1.
REQ-036 Macro on: word load 0x8000_0001 -> resp_err=1 cycle 1, ar_valid never 1; macro off: ar_valid=1, ar_addr=0x8000_0001.
